// File: rtl/bitstream_pkg.sv
// Shared types and constants for the bitstream generator / counter family.
package bitstream_pkg;

  // Pattern generator FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StHigh,
    StLow,
    StTail
  } bs_state_e;

  // Shortest usable window; smaller programmed periods are clamped up to this.
  localparam int unsigned P_MIN_PERIOD = 2;

  // PRBS15, x^15 + x^14 + 1 (Fibonacci form, feedback from bits 14 and 13).
  localparam logic [14:0] LFSR_TAPS = 15'h6000;
  localparam logic [14:0] LFSR_SEED = 15'h0001;

endpackage

// File: rtl/bitstream_gen_if.sv
// Control/status bundle of bitstream_gen. The master side drives config and enable,
// the slave side (the generator) returns the stream and per-window tallies.
// Optional BITSTREAM_GEN_PRBS_EN adds the prbs_sel select line.
interface bitstream_gen_if #(
  parameter int unsigned P_N_WIDTH = 32
) ();

`ifdef BITSTREAM_GEN_PRBS_EN
  logic                 prbs_sel;
`endif
  logic                 en;
  logic [P_N_WIDTH-1:0] period;
  logic [P_N_WIDTH-1:0] delay;
  logic [P_N_WIDTH-1:0] n_pulses;
  logic [P_N_WIDTH-1:0] width_high;
  logic [P_N_WIDTH-1:0] width_low;
  logic                 a;
  logic                 busy;
  logic                 update;
  logic                 valid;
  logic [P_N_WIDTH-1:0] n_pedge_sent;
  logic [P_N_WIDTH-1:0] n_high_sent;

  modport master (
`ifdef BITSTREAM_GEN_PRBS_EN
    output prbs_sel,
`endif
    output en, period, delay, n_pulses, width_high, width_low,
    input  a, busy, update, valid, n_pedge_sent, n_high_sent
  );

  modport slave (
`ifdef BITSTREAM_GEN_PRBS_EN
    input  prbs_sel,
`endif
    input  en, period, delay, n_pulses, width_high, width_low,
    output a, busy, update, valid, n_pedge_sent, n_high_sent
  );

endinterface

// File: rtl/bitstream_tally.sv
// Per-window accumulator of rising edges and high cycles of a bit stream.
// Saturates at all-ones; on update the closing window (including the update
// cycle itself) is latched to the outputs and the accumulators restart.
module bitstream_tally #(
  parameter int unsigned P_N_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active_i,
  input  logic                 a_i,
  input  logic                 update_i,
  output logic [P_N_WIDTH-1:0] n_pedge_o,
  output logic [P_N_WIDTH-1:0] n_high_o
);

  localparam logic [P_N_WIDTH-1:0] One = P_N_WIDTH'(1);

  logic                 a_prev_q, a_prev_d;
  logic [P_N_WIDTH-1:0] pe_acc_q, pe_acc_d;
  logic [P_N_WIDTH-1:0] hi_acc_q, hi_acc_d;
  logic [P_N_WIDTH-1:0] pe_out_q, pe_out_d;
  logic [P_N_WIDTH-1:0] hi_out_q, hi_out_d;
  logic [P_N_WIDTH-1:0] pe_sum, hi_sum;

  function automatic logic [P_N_WIDTH-1:0] sat_inc(input logic [P_N_WIDTH-1:0] x,
                                                   input logic inc);
    return (inc && (x != '1)) ? x + One : x;
  endfunction

  // Running sums including the current cycle; a_prev spans window boundaries.
  always_comb begin
    pe_sum   = sat_inc(pe_acc_q, a_i & ~a_prev_q);
    hi_sum   = sat_inc(hi_acc_q, a_i);
    a_prev_d = a_i;
    pe_acc_d = pe_acc_q;
    hi_acc_d = hi_acc_q;
    pe_out_d = pe_out_q;
    hi_out_d = hi_out_q;
    if (!active_i) begin
      pe_acc_d = '0;
      hi_acc_d = '0;
    end else if (update_i) begin
      pe_out_d = pe_sum;
      hi_out_d = hi_sum;
      pe_acc_d = '0;
      hi_acc_d = '0;
    end else begin
      pe_acc_d = pe_sum;
      hi_acc_d = hi_sum;
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_prev_q <= 1'b0;
      pe_acc_q <= '0;
      hi_acc_q <= '0;
      pe_out_q <= '0;
      hi_out_q <= '0;
    end else begin
      a_prev_q <= a_prev_d;
      pe_acc_q <= pe_acc_d;
      hi_acc_q <= hi_acc_d;
      pe_out_q <= pe_out_d;
      hi_out_q <= hi_out_d;
    end
  end

  assign n_pedge_o = pe_out_q;
  assign n_high_o  = hi_out_q;

endmodule

// File: rtl/bitstream_gen.sv
// Programmable pulse-train transmitter with per-window tallies of what it sent.
// Window: delay low cycles, then n_pulses of width_high high / width_low low,
// then low until the window of `period` clocks ends. Config is sampled when a
// window begins. Optional BITSTREAM_GEN_PRBS_EN adds a PRBS15 source on prbs_sel.
module bitstream_gen #(
  parameter int unsigned P_N_WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  bitstream_gen_if.slave bus
);
  import bitstream_pkg::*;

  localparam logic [P_N_WIDTH-1:0] One       = P_N_WIDTH'(1);
  localparam logic [P_N_WIDTH-1:0] MinPeriod = P_N_WIDTH'(P_MIN_PERIOD);

  bs_state_e            state_q, state_d;
  logic [P_N_WIDTH-1:0] wcnt_q, wcnt_d;    // window cycle index
  logic [P_N_WIDTH-1:0] scnt_q, scnt_d;    // cycles spent in current state, incl. this one
  logic [P_N_WIDTH-1:0] pcnt_q, pcnt_d;    // pulses started this window
  logic [P_N_WIDTH-1:0] plen_q, plen_d;
  logic [P_N_WIDTH-1:0] delay_q, delay_d;
  logic [P_N_WIDTH-1:0] npul_q, npul_d;
  logic [P_N_WIDTH-1:0] whigh_q, whigh_d;
  logic [P_N_WIDTH-1:0] wlow_q, wlow_d;
  logic                 a_q, a_d;
  logic                 valid_q, valid_d;
  logic                 busy, win_last, update, pulse_left, pattern;

  assign busy       = (state_q != StIdle);
  assign win_last   = busy && (wcnt_q == plen_q - One);
  assign update     = win_last && bus.en;
  assign pulse_left = (pcnt_q < npul_q) && (whigh_q != '0);

  // Next-state: each edge computes the state for the following window cycle.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    pcnt_d  = pcnt_q;
    plen_d  = plen_q;
    delay_d = delay_q;
    npul_d  = npul_q;
    whigh_d = whigh_q;
    wlow_d  = wlow_q;
    if (!bus.en) begin
      state_d = StIdle;
      wcnt_d  = '0;
      scnt_d  = '0;
      pcnt_d  = '0;
    end else if (!busy || win_last) begin
      // New window: sample config and decide the state for cycle 0.
      plen_d  = (bus.period < MinPeriod) ? MinPeriod : bus.period;
      delay_d = bus.delay;
      npul_d  = bus.n_pulses;
      whigh_d = bus.width_high;
      wlow_d  = bus.width_low;
      wcnt_d  = '0;
      scnt_d  = One;
      pcnt_d  = '0;
      if (bus.delay != '0) begin
        state_d = StDelay;
      end else if ((bus.n_pulses != '0) && (bus.width_high != '0)) begin
        state_d = StHigh;
        pcnt_d  = One;
      end else begin
        state_d = StTail;
        scnt_d  = '0;
      end
    end else begin
      wcnt_d = wcnt_q + One;
      scnt_d = scnt_q + One;
      case (state_q)
        StDelay, StLow: begin
          if (scnt_q == ((state_q == StDelay) ? delay_q : wlow_q)) begin
            scnt_d = One;
            if (pulse_left) begin
              state_d = StHigh;
              pcnt_d  = pcnt_q + One;
            end else begin
              state_d = StTail;
            end
          end
        end
        StHigh: begin
          if (scnt_q == whigh_q) begin
            scnt_d = One;
            if (wlow_q != '0) begin
              state_d = StLow;
            end else if (pulse_left) begin
              pcnt_d = pcnt_q + One;  // back-to-back pulse, a stays high
            end else begin
              state_d = StTail;
            end
          end
        end
        default: scnt_d = scnt_q;
      endcase
    end
  end

`ifdef BITSTREAM_GEN_PRBS_EN
  logic [14:0] lfsr_q, lfsr_d;

  // PRBS15 advances on every cycle of an active window.
  always_comb begin
    lfsr_d = lfsr_q;
    if (busy) begin
      lfsr_d = {lfsr_q[13:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign pattern = bus.prbs_sel ? lfsr_q[14] : (state_d == StHigh);
`else
  assign pattern = (state_d == StHigh);
`endif

  // Output bit and validity flag registered alongside the FSM.
  always_comb begin
    a_d     = (state_d != StIdle) && pattern;
    valid_d = bus.en && (valid_q || update);
  end

  // FSM, counters and latched config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      pcnt_q  <= '0;
      plen_q  <= MinPeriod;
      delay_q <= '0;
      npul_q  <= '0;
      whigh_q <= '0;
      wlow_q  <= '0;
      a_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      pcnt_q  <= pcnt_d;
      plen_q  <= plen_d;
      delay_q <= delay_d;
      npul_q  <= npul_d;
      whigh_q <= whigh_d;
      wlow_q  <= wlow_d;
      a_q     <= a_d;
      valid_q <= valid_d;
    end
  end

  bitstream_tally #(
    .P_N_WIDTH(P_N_WIDTH)
  ) u_tally (
    .clk      (clk),
    .rst      (rst),
    .active_i (busy),
    .a_i      (a_q),
    .update_i (update),
    .n_pedge_o(bus.n_pedge_sent),
    .n_high_o (bus.n_high_sent)
  );

  assign bus.a      = a_q;
  assign bus.busy   = busy;
  assign bus.update = update;
  assign bus.valid  = valid_q;

endmodule
